i2c_write_scheduler: RTL and testbench
======================================

I2C_WRITE_SCHEDULER -- requirements
Module: i2c_write_scheduler

Interface
REQ-001 The block SHALL have exactly these parameters, one per line: name, default, meaning.
  RETRY_MAX     3          retries after the first NACK/timeout (0..15)
  GAP_CLKS      270        idle clocks between engine transactions (1..65535)
  TIMEOUT_CLKS  1000000    max clocks waiting for eng_done (1..2^20-1)
REQ-002 The block SHALL have exactly these ports, one per line: name  direction  width  meaning.
  clk        in   1  27 MHz system clock
  reset      in   1  asynchronous, active-high reset
  r0_valid   in   1  requester 0 (init sequencer) write request
  r0_reg     in   8  requester 0 register address
  r0_data    in   8  requester 0 register data
  r0_ready   out  1  1-cycle accept pulse to requester 0
  r0_done    out  1  1-cycle success pulse to requester 0
  r0_err     out  1  1-cycle failure pulse to requester 0
  r1_valid, r1_reg, r1_data, r1_ready, r1_done, r1_err: same as r0_*, for requester 1 (runtime control)
  eng_valid  out  1  command to the shared I2C write engine
  eng_reg    out  8  register byte to the engine
  eng_data   out  8  data byte to the engine
  eng_ready  in   1  engine accepts the command when eng_valid=1
  eng_done   in   1  1-cycle pulse: transaction finished
  eng_nack   in   1  qualified by eng_done; 1 = slave NACKed
  busy       out  1  1 in any state other than IDLE
  grant      out  1  index of the requester being served, held until the next accept
REQ-003 Clock and reset SHALL be: one clock, clk; reset asynchronous, active-high, named reset.

Function
REQ-004 The FSM SHALL have these states: IDLE, ISSUE, WAIT, GAP.
REQ-005 Arbitration in IDLE SHALL be round-robin. A prio bit names the favoured requester. The prio bit is 0 after reset and toggles to the non-served index after each completion (done or err).
REQ-006 In IDLE with at least one rN_valid asserted, the block SHALL:
  - assert rN_ready for exactly one cycle for the chosen requester;
  - latch rN_reg and rN_data;
  - set grant=N;
  - clear the retry counter;
  - go to ISSUE on the next cycle.
REQ-007 If both requesters are valid in the same cycle, the prio requester SHALL win. The loser SHALL receive no ready pulse.
REQ-008 In ISSUE, eng_valid SHALL be 1 with the latched eng_reg/eng_data, held stable until the cycle in which eng_ready=1. On that cycle the FSM SHALL go to WAIT and load the timeout counter.
REQ-009 eng_valid SHALL be 0 in IDLE, WAIT and GAP. eng_done received outside WAIT SHALL be ignored.
REQ-010 In WAIT, eng_done with eng_nack=0 SHALL produce rG_done for 1 cycle (G=grant) and go to GAP with completion pending.
REQ-011 In WAIT, a failure is either eng_done with eng_nack=1, or TIMEOUT_CLKS clocks elapsed without eng_done. On a failure:
  - if retry count < RETRY_MAX: increment the retry count and go to GAP with retry pending;
  - otherwise: emit rG_err for 1 cycle and go to GAP with completion pending.
REQ-012 If eng_done arrives on the same cycle the timeout expires, eng_done SHALL take precedence.
REQ-013 In GAP, the block SHALL count GAP_CLKS clocks, then go to ISSUE if retry is pending, else to IDLE. New requests SHALL NOT be accepted during GAP.
REQ-014 Exactly one of rG_done or rG_err SHALL be pulsed per accepted request, and never for the non-granted requester.
REQ-015 Minimum accept-to-next-accept spacing SHALL be 1 ISSUE cycle + the engine latency + GAP_CLKS + 1 IDLE cycle.
REQ-016 The retry counter SHALL be 4 bits. The timeout counter SHALL be 20 bits. The gap counter SHALL be 16 bits. No counter SHALL wrap: each saturates at its terminal value and is reloaded on state entry.

Reset
REQ-017 On reset assertion, the block SHALL asynchronously set:
  - state=IDLE, prio=0, grant=0;
  - all counters to 0, latched reg/data to 0x00;
  - eng_valid, busy, and all rN_ready/rN_done/rN_err to 0.
REQ-018 Reset asserted mid-transaction SHALL abandon the request silently, with no done or err pulse. After release, the block SHALL accept a new request no earlier than the first clk edge.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
  - Single write: r0 (reg 0x03, data 0x0D); engine ready immediately, done with nack=0 after 100 clks.
    -> eng_reg=0x03, eng_data=0x0D; one r0_done; busy=0 after 270 gap clks + 1.
  - Contention: r0_valid and r1_valid asserted together from reset.
    -> r0 served first, then r1 (prio toggled); with both still valid afterwards, r0 and r1 alternate.
  - NACK retry: engine NACKs twice, then ACKs.
    -> eng_valid issued 3 times, a 270-clk gap between issues, one r0_done, no r0_err.
  - Exhausted retries: engine always NACKs, RETRY_MAX=3.
    -> 4 issues, then one r1_err, no done.
  - Timeout: engine accepts but never pulses done, TIMEOUT_CLKS=1000.
    -> retry after 1000 clks + gap; err after the 4th timeout; eng_done and timeout on the same cycle counts as a success.
  - Reset mid-WAIT, then release.
    -> all outputs 0 immediately; no pulses; the next request is accepted normally with prio=0.

Source files
------------

// File: rtl/i2c_write_scheduler.sv
// Shares one I2C write engine between two requesters: round-robin accept, issue,
// wait for completion with NACK/timeout retries, then a fixed idle gap.
module i2c_write_scheduler #(
    parameter int RETRY_MAX    = 3,
    parameter int GAP_CLKS     = 270,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       r0_valid,
    input  logic [7:0] r0_reg,
    input  logic [7:0] r0_data,
    output logic       r0_ready,
    output logic       r0_done,
    output logic       r0_err,
    input  logic       r1_valid,
    input  logic [7:0] r1_reg,
    input  logic [7:0] r1_data,
    output logic       r1_ready,
    output logic       r1_done,
    output logic       r1_err,
    output logic       eng_valid,
    output logic [7:0] eng_reg,
    output logic [7:0] eng_data,
    input  logic       eng_ready,
    input  logic       eng_done,
    input  logic       eng_nack,
    output logic       busy,
    output logic       grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    localparam logic [3:0]  RETRY_LIM = 4'(RETRY_MAX);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CLKS - 1);
    localparam logic [19:0] TMO_LOAD  = 20'(TIMEOUT_CLKS - 1);

    state_t      r_state, w_nextState;
    logic        r_prio, w_nextPrio;
    logic        r_grant, w_nextGrant;
    logic        r_retryPend, w_nextRetryPend;
    logic [3:0]  r_retry, w_nextRetry;
    logic [19:0] r_tmo, w_nextTmo;
    logic [15:0] r_gap, w_nextGap;
    logic [7:0]  r_reg, w_nextReg;
    logic [7:0]  r_data, w_nextData;
    logic [1:0]  r_ready, w_nextReady;
    logic [1:0]  r_done, w_nextDone;
    logic [1:0]  r_err, w_nextErr;
    logic        w_pick;
    logic        w_fail;

    // Contention goes to the favoured requester; otherwise whoever is asking.
    assign w_pick = (r0_valid && r1_valid) ? r_prio : r1_valid;
    assign w_fail = (eng_done && eng_nack) || (r_tmo == 20'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio      <= 1'b0;
            r_grant     <= 1'b0;
            r_retryPend <= 1'b0;
            r_retry     <= 4'd0;
            r_tmo       <= 20'd0;
            r_gap       <= 16'd0;
            r_reg       <= 8'h00;
            r_data      <= 8'h00;
            r_ready     <= 2'b00;
            r_done      <= 2'b00;
            r_err       <= 2'b00;
        end else begin
            r_prio      <= w_nextPrio;
            r_grant     <= w_nextGrant;
            r_retryPend <= w_nextRetryPend;
            r_retry     <= w_nextRetry;
            r_tmo       <= w_nextTmo;
            r_gap       <= w_nextGap;
            r_reg       <= w_nextReg;
            r_data      <= w_nextData;
            r_ready     <= w_nextReady;
            r_done      <= w_nextDone;
            r_err       <= w_nextErr;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_nextPrio      = r_prio;
        w_nextGrant     = r_grant;
        w_nextRetryPend = r_retryPend;
        w_nextRetry     = r_retry;
        w_nextTmo       = (r_tmo != 20'd0) ? r_tmo - 20'd1 : r_tmo;
        w_nextGap       = (r_gap != 16'd0) ? r_gap - 16'd1 : r_gap;
        w_nextReg       = r_reg;
        w_nextData      = r_data;
        w_nextReady     = 2'b00;
        w_nextDone      = 2'b00;
        w_nextErr       = 2'b00;

        unique case (r_state)
            IDLE: begin
                if (r0_valid || r1_valid) begin
                    w_nextGrant         = w_pick;
                    w_nextReg           = w_pick ? r1_reg : r0_reg;
                    w_nextData          = w_pick ? r1_data : r0_data;
                    w_nextReady[w_pick] = 1'b1;
                    w_nextRetry         = 4'd0;
                    w_nextRetryPend     = 1'b0;
                    w_nextState         = ISSUE;
                end
            end
            ISSUE: begin
                if (eng_ready) begin
                    w_nextTmo   = TMO_LOAD;
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                // A done landing on the timeout cycle still counts as success.
                if (eng_done && !eng_nack) begin
                    w_nextDone[r_grant] = 1'b1;
                    w_nextPrio          = ~r_grant;
                    w_nextRetryPend     = 1'b0;
                    w_nextGap           = GAP_LOAD;
                    w_nextState         = GAP;
                end else if (w_fail) begin
                    if (r_retry < RETRY_LIM) begin
                        w_nextRetry     = r_retry + 4'd1;
                        w_nextRetryPend = 1'b1;
                    end else begin
                        w_nextErr[r_grant] = 1'b1;
                        w_nextPrio         = ~r_grant;
                        w_nextRetryPend    = 1'b0;
                    end
                    w_nextGap   = GAP_LOAD;
                    w_nextState = GAP;
                end
            end
            GAP: begin
                if (r_gap == 16'd0) begin
                    w_nextState = r_retryPend ? ISSUE : IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign r0_ready  = r_ready[0];
    assign r1_ready  = r_ready[1];
    assign r0_done   = r_done[0];
    assign r1_done   = r_done[1];
    assign r0_err    = r_err[0];
    assign r1_err    = r_err[1];
    assign eng_valid = (r_state == ISSUE);
    assign eng_reg   = r_reg;
    assign eng_data  = r_data;
    assign busy      = (r_state != IDLE);
    assign grant     = r_grant;

endmodule

// File: tb/tb_i2c_write_scheduler.sv
// Directed bench for i2c_write_scheduler: a behavioural engine model answers each
// issued command, and pulse monitors count ready/done/err per requester.
module tb_i2c_write_scheduler;

    logic       clk;
    logic       reset;
    logic       r0_valid, r1_valid;
    logic [7:0] r0_reg, r0_data, r1_reg, r1_data;
    logic       r0_ready, r0_done, r0_err;
    logic       r1_ready, r1_done, r1_err;
    logic       eng_valid, eng_ready, eng_done, eng_nack;
    logic [7:0] eng_reg, eng_data;
    logic       busy, grant;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Engine model controls, written only by the main sequence
    int engLatency = 100;
    int nackBase   = 0;
    int nackCount  = 0;
    bit engSilent  = 0;

    // Engine model observations, written only by the engine process
    int   issueCount = 0;
    int   issueTime[64];
    logic [7:0] issueReg[64];
    logic [7:0] issueData[64];

    // Pulse monitors, written only by the monitor process
    int readyCnt0 = 0, readyCnt1 = 0, doneCnt0 = 0, doneCnt1 = 0;
    int errCnt0 = 0, errCnt1 = 0, bothReady = 0;
    int readyLog[$];

    i2c_write_scheduler #(
        .RETRY_MAX    (3),
        .GAP_CLKS     (270),
        .TIMEOUT_CLKS (1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .r0_valid  (r0_valid),
        .r0_reg    (r0_reg),
        .r0_data   (r0_data),
        .r0_ready  (r0_ready),
        .r0_done   (r0_done),
        .r0_err    (r0_err),
        .r1_valid  (r1_valid),
        .r1_reg    (r1_reg),
        .r1_data   (r1_data),
        .r1_ready  (r1_ready),
        .r1_done   (r1_done),
        .r1_err    (r1_err),
        .eng_valid (eng_valid),
        .eng_reg   (eng_reg),
        .eng_data  (eng_data),
        .eng_ready (eng_ready),
        .eng_done  (eng_done),
        .eng_nack  (eng_nack),
        .busy      (busy),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Engine: a handshake seen at a negedge completes at the next posedge; done
    // is raised engLatency negedges later and held for one cycle.
    initial begin : engineModel
        eng_done = 1'b0;
        eng_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_valid && eng_ready && !reset) begin
                issueCount++;
                if (issueCount < 64) begin
                    issueTime[issueCount] = int'($time / 10);
                    issueReg[issueCount]  = eng_reg;
                    issueData[issueCount] = eng_data;
                end
                if (!engSilent) begin
                    repeat (engLatency) @(negedge clk);
                    eng_nack = ((issueCount - nackBase) <= nackCount);
                    eng_done = 1'b1;
                    @(negedge clk);
                    eng_done = 1'b0;
                    eng_nack = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (r0_ready) begin readyCnt0++; readyLog.push_back(0); end
        if (r1_ready) begin readyCnt1++; readyLog.push_back(1); end
        if (r0_ready && r1_ready) bothReady++;
        if (r0_done) doneCnt0++;
        if (r1_done) doneCnt1++;
        if (r0_err)  errCnt0++;
        if (r1_err)  errCnt1++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one request and returns at the negedge its ready pulse is seen.
    task automatic applyStimulus(input int which, input logic [7:0] regV, input logic [7:0] dataV);
        int n;
        logic seen;
        @(negedge clk);
        if (which == 0) begin r0_valid = 1'b1; r0_reg = regV; r0_data = dataV; end
        else            begin r1_valid = 1'b1; r1_reg = regV; r1_data = dataV; end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            seen = (which == 0) ? r0_ready : r1_ready;
        end
        if (which == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
        if (!seen) checkOutput("readyTimeout", 32'(seen), 32'd1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idleTimeout", 32'(busy), 32'd0);
    endtask

    initial begin : mainSeq
        int iBase, d0, d1, e0, e1, lb, got, n;

        reset = 1'b1; eng_ready = 1'b1;
        r0_valid = 1'b1; r0_reg = 8'h00; r0_data = 8'h00;
        r1_valid = 1'b0; r1_reg = 8'h00; r1_data = 8'h00;

        // Reset state, with a request already pending
        repeat (3) @(negedge clk);
        checkOutput("rstBusy",  32'(busy), 32'd0);
        checkOutput("rstEngV",  32'(eng_valid), 32'd0);
        checkOutput("rstReady", 32'({r0_ready, r1_ready}), 32'd0);
        checkOutput("rstGrant", 32'(grant), 32'd0);
        checkOutput("rstEngReg", 32'(eng_reg), 32'h00);
        r0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Single write with engine stalling in ISSUE first
        $display("[TB] single write");
        eng_ready = 1'b0; engLatency = 100; nackCount = 0; nackBase = issueCount; engSilent = 0;
        iBase = issueCount; d0 = doneCnt0; e0 = errCnt0;
        applyStimulus(0, 8'h03, 8'h0D);
        repeat (5) @(negedge clk);
        checkOutput("s1HoldV",    32'(eng_valid), 32'd1);
        checkOutput("s1HoldReg",  32'(eng_reg), 32'h03);
        checkOutput("s1HoldData", 32'(eng_data), 32'h0D);
        checkOutput("s1Grant",    32'(grant), 32'd0);
        #2 eng_ready = 1'b1;
        n = 0;
        while (!r0_done && n < 2000) begin @(negedge clk); n++; end
        checkOutput("s1DoneSeen", 32'(r0_done), 32'd1);
        n = 0;
        while (busy && n < 1000) begin n++; @(negedge clk); end
        checkOutput("s1GapLen", 32'(n), 32'd270);
        checkOutput("s1Issues", 32'(issueCount - iBase), 32'd1);
        checkOutput("s1EngReg", 32'(issueReg[iBase+1]), 32'h03);
        checkOutput("s1EngData", 32'(issueData[iBase+1]), 32'h0D);
        checkOutput("s1Done", 32'(doneCnt0 - d0), 32'd1);
        checkOutput("s1Err",  32'(errCnt0 - e0), 32'd0);

        // Contention from reset: both held valid, service must alternate
        $display("[TB] contention");
        @(negedge clk);
        reset = 1'b1;
        r0_valid = 1'b1; r0_reg = 8'hA0; r0_data = 8'h11;
        r1_valid = 1'b1; r1_reg = 8'hB1; r1_data = 8'h22;
        repeat (2) @(negedge clk);
        checkOutput("s2RstReady", 32'({r0_ready, r1_ready}), 32'd0);
        reset = 1'b0;
        engLatency = 10; nackBase = issueCount;
        lb = readyLog.size(); iBase = issueCount; d0 = doneCnt0; d1 = doneCnt1;
        got = 0; n = 0;
        while (got < 4 && n < 5000) begin
            @(negedge clk);
            n++;
            if (r0_ready || r1_ready) got++;
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        waitIdle(2000);
        checkOutput("s2Accepts", 32'(got), 32'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("s2Order%0d", k),
                        32'((lb + k < readyLog.size()) ? readyLog[lb+k] : 9), 32'(k % 2));
            checkOutput($sformatf("s2Reg%0d", k), 32'(issueReg[iBase+1+k]), (k % 2 == 0) ? 32'hA0 : 32'hB1);
        end
        checkOutput("s2Done0", 32'(doneCnt0 - d0), 32'd2);
        checkOutput("s2Done1", 32'(doneCnt1 - d1), 32'd2);
        checkOutput("s2Both",  32'(bothReady), 32'd0);

        // NACK twice, then ACK
        $display("[TB] nack retry");
        engLatency = 50; nackBase = issueCount; nackCount = 2;
        iBase = issueCount; d0 = doneCnt0; e0 = errCnt0;
        applyStimulus(0, 8'h21, 8'h5A);
        waitIdle(5000);
        checkOutput("s3Issues", 32'(issueCount - iBase), 32'd3);
        checkOutput("s3Space1", 32'(issueTime[iBase+2] - issueTime[iBase+1]), 32'd321);
        checkOutput("s3Space2", 32'(issueTime[iBase+3] - issueTime[iBase+2]), 32'd321);
        checkOutput("s3RetryReg", 32'(issueReg[iBase+3]), 32'h21);
        checkOutput("s3Done", 32'(doneCnt0 - d0), 32'd1);
        checkOutput("s3Err",  32'(errCnt0 - e0), 32'd0);

        // Always NACK: four attempts then one error to requester 1
        $display("[TB] exhausted retries");
        nackBase = issueCount; nackCount = 100;
        iBase = issueCount; d0 = doneCnt0 + errCnt0; d1 = doneCnt1; e1 = errCnt1;
        applyStimulus(1, 8'h40, 8'h7F);
        waitIdle(5000);
        checkOutput("s4Issues", 32'(issueCount - iBase), 32'd4);
        checkOutput("s4Err1",  32'(errCnt1 - e1), 32'd1);
        checkOutput("s4Done1", 32'(doneCnt1 - d1), 32'd0);
        checkOutput("s4R0Quiet", 32'(doneCnt0 + errCnt0 - d0), 32'd0);

        // Engine never answers: timeout-driven retries
        $display("[TB] timeout");
        engSilent = 1; nackCount = 0; nackBase = issueCount;
        iBase = issueCount; d0 = doneCnt0; e0 = errCnt0;
        applyStimulus(0, 8'h55, 8'hAA);
        waitIdle(10000);
        checkOutput("s5Issues", 32'(issueCount - iBase), 32'd4);
        checkOutput("s5Space1", 32'(issueTime[iBase+2] - issueTime[iBase+1]), 32'd1271);
        checkOutput("s5Space3", 32'(issueTime[iBase+4] - issueTime[iBase+3]), 32'd1271);
        checkOutput("s5Err",  32'(errCnt0 - e0), 32'd1);
        checkOutput("s5Done", 32'(doneCnt0 - d0), 32'd0);

        // Done on the very cycle the timeout expires counts as success
        $display("[TB] done at timeout");
        engSilent = 0; engLatency = 1000; nackBase = issueCount;
        iBase = issueCount; d0 = doneCnt0; e0 = errCnt0;
        applyStimulus(0, 8'h31, 8'h13);
        waitIdle(3000);
        checkOutput("s5bIssues", 32'(issueCount - iBase), 32'd1);
        checkOutput("s5bDone", 32'(doneCnt0 - d0), 32'd1);
        checkOutput("s5bErr",  32'(errCnt0 - e0), 32'd0);

        // Done one cycle late lands in GAP and must be ignored
        $display("[TB] late done");
        engLatency = 1001; nackBase = issueCount;
        iBase = issueCount; d0 = doneCnt0; e0 = errCnt0;
        applyStimulus(0, 8'h32, 8'h23);
        waitIdle(10000);
        checkOutput("s5cIssues", 32'(issueCount - iBase), 32'd4);
        checkOutput("s5cDone", 32'(doneCnt0 - d0), 32'd0);
        checkOutput("s5cErr",  32'(errCnt0 - e0), 32'd1);

        // Reset in WAIT: abandoned silently, prio back to requester 0
        $display("[TB] reset mid-wait");
        engSilent = 1;
        applyStimulus(1, 8'h66, 8'h99);
        repeat (20) @(negedge clk);
        checkOutput("s6PreBusy",  32'(busy), 32'd1);
        checkOutput("s6PreGrant", 32'(grant), 32'd1);
        d1 = doneCnt1; e1 = errCnt1;
        reset = 1'b1;
        #1;
        checkOutput("s6RstBusy",  32'(busy), 32'd0);
        checkOutput("s6RstEngV",  32'(eng_valid), 32'd0);
        checkOutput("s6RstGrant", 32'(grant), 32'd0);
        checkOutput("s6RstPulses", 32'({r0_ready, r0_done, r0_err, r1_ready, r1_done, r1_err}), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("s6NoDone", 32'(doneCnt1 - d1), 32'd0);
        checkOutput("s6NoErr",  32'(errCnt1 - e1), 32'd0);
        engSilent = 0; engLatency = 10; nackBase = issueCount;
        iBase = issueCount; d0 = doneCnt0;
        r0_valid = 1'b1; r0_reg = 8'h12; r0_data = 8'h34;
        r1_valid = 1'b1; r1_reg = 8'h56; r1_data = 8'h78;
        n = 0;
        while (!(r0_ready || r1_ready) && n < 100) begin @(negedge clk); n++; end
        checkOutput("s6WinR0", 32'({r0_ready, r1_ready}), 32'b10);
        r0_valid = 1'b0; r1_valid = 1'b0;
        waitIdle(2000);
        checkOutput("s6Reg",  32'(issueReg[iBase+1]), 32'h12);
        checkOutput("s6Done", 32'(doneCnt0 - d0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
